// File: rtl/imm_packer.sv
// imm_packer: encode-side immediate packer for the RV32 code-patch path.
// Range-checks an immediate against its format, scatters it into the
// template's immediate fields and emits the result through a 2-stage
// valid/ready pipeline. Error beats pass the template through untouched
// and are counted by a saturating counter.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   in_valid/in_ready      input handshake (in_ready combinational from out_ready)
//   in_instr, in_imm       template and immediate value
//   in_fmt                 000 I, 001 IU, 010 S, 011 SB, 100 UJ, 101 U
//   out_valid/out_ready    output handshake
//   out_instr, out_err     packed word, range/format error flag
//   err_clr, err_cnt       clear and value of the saturating error counter

package imm_packer_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FMTW = 3;
  localparam int unsigned CNTW = 8;
  localparam int unsigned IMMW = 20;

  localparam logic [FMTW-1:0] FMT_I  = 3'b000;
  localparam logic [FMTW-1:0] FMT_IU = 3'b001;
  localparam logic [FMTW-1:0] FMT_S  = 3'b010;
  localparam logic [FMTW-1:0] FMT_SB = 3'b011;
  localparam logic [FMTW-1:0] FMT_UJ = 3'b100;
  localparam logic [FMTW-1:0] FMT_U  = 3'b101;

  // Stage-1 payload; only imm[19:0] is ever scattered, so the rest is dropped
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [IMMW-1:0] imm;
    logic [FMTW-1:0] fmt;
    logic            ok;
  } s1_t;
endpackage

module imm_packer
  import imm_packer_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_imm,
  input  logic [FMTW-1:0] in_fmt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic            out_err,
  input  logic            err_clr,
  output logic [CNTW-1:0] err_cnt
);

  logic            s1_valid;
  s1_t             s1_q;
  logic            s1_adv;
  logic            s2_adv;
  logic            range_ok;
  logic [XLEN-1:0] packed_word;
  logic            err_xfer;

  // Pipeline advance; a stalled output backs up into stage 1, then the input
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign err_xfer = out_valid && out_ready && out_err;

  // Range check: upper bits must be a pure sign (signed) or zero (unsigned) extension
  always_comb begin
    range_ok = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S, FMT_SB: range_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
      FMT_IU:               range_ok = !(|in_imm[31:12]);
      FMT_UJ:               range_ok = (&in_imm[31:19]) || !(|in_imm[31:19]);
      FMT_U:                range_ok = !(|in_imm[31:20]);
      default:              range_ok = 1'b0;
    endcase
  end

  // Stage 1: capture template, low immediate bits, format and check result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.instr <= in_instr;
        s1_q.imm   <= in_imm[IMMW-1:0];
        s1_q.fmt   <= in_fmt;
        s1_q.ok    <= range_ok;
      end
    end
  end

  // Scatter the immediate into the format's fields; error beats keep the template
  always_comb begin
    packed_word = s1_q.instr;
    if (s1_q.ok) begin
      case (s1_q.fmt)
        FMT_I, FMT_IU: packed_word[31:20] = s1_q.imm[11:0];
        FMT_S: begin
          packed_word[31:25] = s1_q.imm[11:5];
          packed_word[11:7]  = s1_q.imm[4:0];
        end
        FMT_SB: begin
          packed_word[31]    = s1_q.imm[11];
          packed_word[7]     = s1_q.imm[10];
          packed_word[30:25] = s1_q.imm[9:4];
          packed_word[11:8]  = s1_q.imm[3:0];
        end
        FMT_UJ: begin
          packed_word[31]    = s1_q.imm[19];
          packed_word[19:12] = s1_q.imm[18:11];
          packed_word[20]    = s1_q.imm[10];
          packed_word[30:21] = s1_q.imm[9:0];
        end
        FMT_U:   packed_word[31:12] = s1_q.imm[19:0];
        default: packed_word = s1_q.instr;
      endcase
    end
  end

  // Stage 2: output register; data holds while stalled or empty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= packed_word;
        out_err   <= !s1_q.ok;
      end
    end
  end

  // Saturating error counter; a clear still counts a coincident error transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= CNTW'(err_xfer);
    end else if (err_xfer && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNTW'(1);
    end
  end

endmodule

// File: doc/imm_packer.md
# imm_packer

Immediate packer for the RV32 code-patch path: the encode-side counterpart of the core's immediate extender. It takes an instruction template, a 32-bit immediate value and a format code, range-checks the immediate, and scatters it into the format's instruction bit fields. The result goes out through a 2-stage valid/ready pipeline toward the instruction-memory write port. A saturating error counter sits alongside for the boot/relocation controller.

## Interface
- No parameters; all widths fixed (32-bit instructions, 3-bit format, 8-bit counter).
- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_instr  in  32  template; immediate bit fields are overwritten, all other bits are passed through
- in_imm  in  32  immediate value, in the units the extender produces (SB/UJ are half-word offsets, not shifted)
- in_fmt  in  3  000 I, 001 IU, 010 S, 011 SB, 100 UJ, 101 U; 110/111 illegal
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_instr  out  32  packed instruction
- out_err  out  1  beat failed range check or had an illegal format
- err_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  8  count of error beats, saturates at 255

## Operation
- Range rules:
  - I, S, SB: in_imm[31:11] all equal (12-bit signed).
  - IU: in_imm[31:12]==0.
  - UJ: in_imm[31:19] all equal (20-bit signed).
  - U: in_imm[31:20]==0.
- Scatter rules (imm = in_imm; all non-listed bits come from in_instr):
  - I/IU: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - SB: [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0].
  - UJ: [31]=imm[19], [19:12]=imm[18:11], [20]=imm[10], [30:21]=imm[9:0].
  - U: [31:12]=imm[19:0].
- Round-trip property: for every in-range beat, applying the core's EXT decode to out_instr with the same format code returns in_imm exactly.
- Error beat (range fail or fmt 110/111):
  - out_instr = in_instr unchanged, out_err=1.
  - The beat still flows through the pipeline and is never dropped.
- Stage 1 registers the template, immediate and format, and computes the range check.
- Stage 2 registers the packed word and out_err.
- err_cnt:
  - Increments by 1 when an error beat transfers at the output (out_valid && out_ready && out_err).
  - Saturates at 255.
  - err_clr forces err_cnt to 0. If err_clr and an error transfer happen in the same cycle, the next value is 1.

## Timing
- Reset (async assert, sync deassert at rstn rise): s1_valid=0, out_valid=0, out_instr=0, out_err=0, err_cnt=0. Outputs take these values immediately on rstn falling.
- Latency: a beat accepted at edge N is presented at out_valid after edge N+1, so it is visible in cycle N+1→N+2. Throughput is 1 beat per cycle when out_ready=1.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. The combinational path out_ready→in_ready is permitted.
- out_instr and out_err are held stable while out_valid && !out_ready.
- Full condition: both stages valid and out_ready=0, which gives in_ready=0. Beats are never lost or reordered.
- Empty condition: out_valid=0; out_instr keeps its last value.
- Reset mid-operation discards both stages; no partial beat is emitted after rstn rises.

## Test plan
- I/IU/U packing, out_ready=1:
  - fmt=000, instr=0x00000013, imm=0xFFFFFFFF -> 0xFFF00013, err=0, two cycles after acceptance.
  - fmt=001, imm=0x00000FFF -> 0xFFF00013.
  - fmt=101, imm=0x00100000 -> instr unchanged, err=1, err_cnt=1.
- S/SB:
  - fmt=010, instr=0x00002023, imm=0xFFFFF805 -> 0x800022A3.
  - fmt=011, instr=0x00000063, imm=0x000007FF -> 0x7E000FE3.
  - fmt=011, imm=0x00000800 -> err=1.
- UJ boundary:
  - fmt=100, instr=0x0000006F, imm=0xFFF80000 -> 0x8000006F.
  - imm=0x00080000 -> err=1.
  - fmt=110 -> err=1.
- Backpressure: stream beats A,B,C,D with out_ready=0 for 4 cycles.
  - in_ready drops after A and B are accepted.
  - A is held stable on the output.
  - After out_ready=1, the output order is A,B,C,D with no gaps.
- Counter:
  - 256 error beats -> err_cnt=255, held there.
  - err_clr coincident with an error transfer -> err_cnt=1.
  - err_clr alone -> 0.
- Async reset with both stages full -> out_valid=0, out_instr=0 and err_cnt=0 in the same cycle. The first beat after release emerges with 2-cycle latency.
